ram_load_check_ctrl: RTL and testbench
======================================

Name: ram_load_check_ctrl

Overview:
- Synthesizable owner of the data-RAM port around the single-cycle core, with parametrised address/data width, run length and RAM read latency.
- Phase 1: preloads RAM words through a valid/ready stream while the core is held.
- Phase 2: releases the core for a programmed cycle count.
- Phase 3: reclaims the port and runs equal / not-equal checks against expected words, counting passes and failures.

Parameters:
AW, 32, RAM address width
DW, 32, RAM data width
RUN_CYCLES, 600, core run length in clocks; legal range 1..2^CW-1
CW, 16, width of run counter and pass/fail counters
RD_LAT, 1, RAM read latency in clocks; 0 = combinational read, 1 = registered read

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; leaves IDLE
load_valid  in  1  preload word valid
load_ready  out  1  preload word accepted
load_addr  in  AW  preload address
load_data  in  DW  preload data
load_last  in  1  marks final preload word
core_hold  out  1  high = core held in reset, RAM port owned by controller
core_we  in  1  core store enable
core_addr  in  AW  core ALU address
core_wdata  in  DW  core store data
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data (also routed to core externally)
chk_valid  in  1  check request valid
chk_ready  out  1  check request accepted
chk_addr  in  AW  address to check
chk_expect  in  DW  expected word
chk_neq  in  1  0 = pass if equal; 1 = pass if not equal
chk_last  in  1  final check request
pass_cnt  out  CW  passed checks
fail_cnt  out  CW  failed checks
done  out  1  sequence complete
busy  out  1  state != IDLE and state != DONE

Behaviour:
- Reset (async, reset = 0), all outputs:
  - state = IDLE, core_hold = 1, done = 0, busy = 0
  - counters = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0
  - load_ready = 0, chk_ready = 0
  - Reset asserted mid-phase aborts immediately, with no further RAM writes.
- IDLE:
  - core_hold = 1.
  - start → LOAD; clear pass_cnt, fail_cnt and done.
- LOAD:
  - load_ready = 1.
  - Each load_valid & load_ready cycle drives ram_we = 1, ram_addr = load_addr, ram_wdata = load_data combinationally in the same cycle.
  - Accepted load_last → RUN next cycle.
  - start is ignored outside IDLE and DONE.
- RUN:
  - core_hold = 0 and the RAM mux selects the core: ram_we = core_we, ram_addr = core_addr, ram_wdata = core_wdata.
  - The run counter counts 0..RUN_CYCLES-1, then → CHECK with core_hold = 1 in the same edge.
  - A store issued in the final RUN cycle completes.
- CHECK:
  - Sub-states CK_REQ and CK_WAIT.
  - CK_REQ: chk_ready = 1. On acceptance, register chk_addr, chk_expect, chk_neq and chk_last; ram_addr = registered address; ram_we = 0.
  - RD_LAT = 0: compare in the acceptance cycle; one check per cycle.
  - RD_LAT = 1: chk_ready drops; CK_WAIT compares ram_rdata one cycle later, then returns to CK_REQ.
  - Compare result = (ram_rdata == expect) XOR neq; increment pass_cnt or fail_cnt.
  - Both counters saturate at all-ones; no wrap.
  - After the compare of a chk_last request → DONE.
- DONE:
  - done = 1 (level), core_hold = 1, counters stable.
  - start → LOAD, clearing counters and done.
- LOAD with load_last on the first word is legal (single-word preload).
- Check with no prior load is impossible; zero checks is not supported (at least one chk_last is required).

Optional Feature:
RAM_CHK_FAILCAP_EN
- Defined: adds outputs fail_addr [AW], fail_got [DW], fail_seen [1].
  - Captures the address and read data of the first failing check in the sequence.
  - Cleared on start and on reset; held thereafter.
- Undefined: ports absent; no capture registers.

Decomposition:
- Package ram_chk_pkg: state enum (IDLE, LOAD, RUN, CHECK, DONE), check sub-state enum, RAM mux-select constants.
- One sub-module ram_port_mux: purely combinational owner select between load, core and check sources, so the arbitration is verified in isolation.

Test Plan:
- Reset mid-LOAD (assert after 2 of 4 words) → ram_we = 0 immediately, state IDLE, core_hold = 1, counters 0.
- Preload 0x60 = 0x0, 0x64 = 0x0, last word flagged; RUN 30 cycles with a core model storing 0x7 @0x60 and 0x19 @0x64 → core_hold falls exactly 1 cycle after load_last acceptance and rises after 30 cycles.
- Checks (RD_LAT = 1): 0x60 == 0x7, 0x64 == 0x19, 0x2 == 0x7, 0xF != 0x44, 0x14 == 0x68 (last), RAM seeded to match → pass_cnt = 5, fail_cnt = 0, done = 1, one check every 2 cycles.
- Same sequence with 0x64 seeded 0x18 → pass_cnt = 4, fail_cnt = 1; with RAM_CHK_FAILCAP_EN: fail_addr = 0x64, fail_got = 0x18.
- CW = 2, six failing checks → fail_cnt saturates at 3.
- RD_LAT = 0, back-to-back chk_valid → one compare per cycle; second start from DONE clears counters and reruns.

Source files
------------

// File: rtl/ram_chk_pkg.sv
// ---------------------------------------------------------------------------
// ram_chk_pkg
// Shared types and constants for the RAM load / run / check controller.
//   state_t   : top-level sequence state (IDLE, LOAD, RUN, CHECK, DONE)
//   ck_sub_t  : CHECK sub-state (CK_REQ accepts a request, CK_WAIT compares)
//   MUX_*     : RAM port owner select codes consumed by ram_port_mux
//   is_busy() : true while a sequence is in flight
// No ports (package).
// ---------------------------------------------------------------------------
package ram_chk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        CK_REQ  = 1'b0,
        CK_WAIT = 1'b1
    } ck_sub_t;

    localparam logic [1:0] MUX_NONE  = 2'd0;
    localparam logic [1:0] MUX_LOAD  = 2'd1;
    localparam logic [1:0] MUX_CORE  = 2'd2;
    localparam logic [1:0] MUX_CHECK = 2'd3;

    function automatic logic is_busy(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/ram_port_mux.sv
// ---------------------------------------------------------------------------
// ram_port_mux
// Purely combinational owner select for the data-RAM port.
//   i_sel          : MUX_* code from ram_chk_pkg
//   i_load_we/addr/wdata : preload stream source
//   i_core_we/addr/wdata : core source
//   i_chk_addr     : checker read address (never writes)
//   o_ram_we/addr/wdata  : RAM port
// MUX_NONE drives an idle, all-zero port.
// ---------------------------------------------------------------------------
module ram_port_mux
    import ram_chk_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic [1:0]    i_sel,
    input  logic          i_load_we,
    input  logic [AW-1:0] i_load_addr,
    input  logic [DW-1:0] i_load_wdata,
    input  logic          i_core_we,
    input  logic [AW-1:0] i_core_addr,
    input  logic [DW-1:0] i_core_wdata,
    input  logic [AW-1:0] i_chk_addr,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata
);

    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        case (i_sel)
            MUX_LOAD: begin
                o_ram_we    = i_load_we;
                o_ram_addr  = i_load_addr;
                o_ram_wdata = i_load_wdata;
            end
            MUX_CORE: begin
                o_ram_we    = i_core_we;
                o_ram_addr  = i_core_addr;
                o_ram_wdata = i_core_wdata;
            end
            MUX_CHECK: begin
                o_ram_addr  = i_chk_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_load_check_ctrl.sv
// ---------------------------------------------------------------------------
// ram_load_check_ctrl
// Owns the data-RAM port around a single-cycle core:
//   LOAD  : preload words from a valid/ready stream, core held
//   RUN   : core released for RUN_CYCLES clocks, RAM port given to the core
//   CHECK : port reclaimed, equal / not-equal checks counted as pass / fail
//   DONE  : results held until the next start
// Ports:
//   clk, reset (async, active low), start (pulse, honoured in IDLE/DONE)
//   load_valid/ready/addr/data/last : preload stream
//   core_hold : high = core in reset and port owned by this block
//   core_we/addr/wdata : core store port
//   ram_we/addr/wdata/rdata : RAM port (RD_LAT 0 = comb read, 1 = registered)
//   chk_valid/ready/addr/expect/neq/last : check request stream
//   pass_cnt, fail_cnt : saturating result counters (CW bits)
//   done (level in DONE), busy (not IDLE and not DONE), dbg_state
// Optional build macro RAM_CHK_FAILCAP_EN adds fail_addr, fail_got and
// fail_seen, capturing the first failing check of a sequence.
//
// Handshakes: a word / request transfers on a rising edge where valid and
// ready are both high; ready depends only on state, never on valid.
// ---------------------------------------------------------------------------
module ram_load_check_ctrl
    import ram_chk_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RUN_CYCLES = 600,
    parameter int CW         = 16,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          core_hold,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          chk_valid,
    output logic          chk_ready,
    input  logic [AW-1:0] chk_addr,
    input  logic [DW-1:0] chk_expect,
    input  logic          chk_neq,
    input  logic          chk_last,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          done,
    output logic          busy,
`ifdef RAM_CHK_FAILCAP_EN
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_got,
    output logic          fail_seen,
`endif
    output state_t        dbg_state
);

    localparam bit            LAT0     = (RD_LAT == 0);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        r_state;
    ck_sub_t       r_ck_sub;
    logic [CW-1:0] r_run_cnt;
    logic [CW-1:0] r_pass_cnt;
    logic [CW-1:0] r_fail_cnt;
    logic [AW-1:0] r_chk_addr;
    logic [DW-1:0] r_chk_expect;
    logic          r_chk_neq;
    logic          r_chk_last;

    state_t        w_state_nxt;
    ck_sub_t       w_ck_sub_nxt;
    logic [1:0]    w_mux_sel;
    logic          w_start_seq;
    logic          w_chk_take;
    logic          w_cmp_en;
    logic [AW-1:0] w_chk_addr;
    logic [DW-1:0] w_cmp_expect;
    logic          w_cmp_neq;
    logic          w_cmp_pass;
    logic          w_run_last;

    assign w_run_last = (r_run_cnt == RUN_LAST);
    assign w_cmp_pass = (ram_rdata == w_cmp_expect) ^ w_cmp_neq;

    always_comb begin
        w_state_nxt  = r_state;
        w_ck_sub_nxt = r_ck_sub;
        w_mux_sel    = MUX_NONE;
        w_start_seq  = 1'b0;
        w_chk_take   = 1'b0;
        w_cmp_en     = 1'b0;
        w_chk_addr   = r_chk_addr;
        w_cmp_expect = r_chk_expect;
        w_cmp_neq    = r_chk_neq;
        load_ready   = 1'b0;
        chk_ready    = 1'b0;
        core_hold    = 1'b1;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_start_seq = 1'b1;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                w_mux_sel  = MUX_LOAD;
                if (load_valid && load_last) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                core_hold = 1'b0;
                w_mux_sel = MUX_CORE;
                if (w_run_last) begin
                    w_state_nxt  = CHECK;
                    w_ck_sub_nxt = CK_REQ;
                end
            end
            CHECK: begin
                w_mux_sel = MUX_CHECK;
                if (r_ck_sub == CK_REQ) begin
                    chk_ready = 1'b1;
                    if (chk_valid) begin
                        w_chk_take = 1'b1;
                        // The live address goes to the RAM in the acceptance
                        // cycle: a combinational RAM answers now, a registered
                        // RAM samples it on this edge and answers in CK_WAIT.
                        w_chk_addr = chk_addr;
                        if (LAT0) begin
                            w_cmp_en     = 1'b1;
                            w_cmp_expect = chk_expect;
                            w_cmp_neq    = chk_neq;
                            if (chk_last) begin
                                w_state_nxt = DONE;
                            end
                        end else begin
                            w_ck_sub_nxt = CK_WAIT;
                        end
                    end
                end else begin
                    w_cmp_en     = 1'b1;
                    w_ck_sub_nxt = CK_REQ;
                    if (r_chk_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_ck_sub     <= CK_REQ;
            r_run_cnt    <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_chk_addr   <= '0;
            r_chk_expect <= '0;
            r_chk_neq    <= 1'b0;
            r_chk_last   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ck_sub <= w_ck_sub_nxt;

            // Counter sits at 0 outside RUN so every run starts from 0.
            if ((r_state == RUN) && !w_run_last) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end else begin
                r_run_cnt <= '0;
            end

            if (w_chk_take) begin
                r_chk_addr   <= chk_addr;
                r_chk_expect <= chk_expect;
                r_chk_neq    <= chk_neq;
                r_chk_last   <= chk_last;
            end

            if (w_start_seq) begin
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else if (w_cmp_en) begin
                if (w_cmp_pass) begin
                    if (r_pass_cnt != CNT_MAX) begin
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                    end
                end else begin
                    if (r_fail_cnt != CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef RAM_CHK_FAILCAP_EN
    logic [AW-1:0] r_fail_addr;
    logic [DW-1:0] r_fail_got;
    logic          r_fail_seen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fail_addr <= '0;
            r_fail_got  <= '0;
            r_fail_seen <= 1'b0;
        end else if (w_start_seq) begin
            r_fail_addr <= '0;
            r_fail_got  <= '0;
            r_fail_seen <= 1'b0;
        end else if (w_cmp_en && !w_cmp_pass && !r_fail_seen) begin
            r_fail_addr <= w_chk_addr;
            r_fail_got  <= ram_rdata;
            r_fail_seen <= 1'b1;
        end
    end

    assign fail_addr = r_fail_addr;
    assign fail_got  = r_fail_got;
    assign fail_seen = r_fail_seen;
`endif

    ram_port_mux #(
        .AW (AW),
        .DW (DW)
    ) u_port_mux (
        .i_sel        (w_mux_sel),
        .i_load_we    (load_valid),
        .i_load_addr  (load_addr),
        .i_load_wdata (load_data),
        .i_core_we    (core_we),
        .i_core_addr  (core_addr),
        .i_core_wdata (core_wdata),
        .i_chk_addr   (w_chk_addr),
        .o_ram_we     (ram_we),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata)
    );

    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign done      = (r_state == DONE);
    assign busy      = is_busy(r_state);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_load_check_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_load_check_ctrl
// Two controllers share clock, reset and stimulus buses:
//   u_dut_a : RUN_CYCLES=30, CW=16, RD_LAT=1 with a registered-read RAM model
//   u_dut_b : RUN_CYCLES=3,  CW=2,  RD_LAT=0 with a combinational RAM model
// Only the controller that was started reacts; the other idles in IDLE/DONE.
// sel_b picks which controller the cur_* views and driver tasks look at.
// ---------------------------------------------------------------------------
module tb_ram_load_check_ctrl;
    import ram_chk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic        load_valid, load_last;
    logic [31:0] load_addr, load_data;
    logic        core_we;
    logic [31:0] core_addr, core_wdata;
    logic        chk_valid, chk_neq, chk_last;
    logic [31:0] chk_addr, chk_expect;

    logic        load_ready_a, core_hold_a, ram_we_a, chk_ready_a, done_a, busy_a;
    logic [31:0] ram_addr_a, ram_wdata_a, ram_rdata_a;
    logic [15:0] pass_cnt_a, fail_cnt_a;
    state_t      dbg_state_a;
    logic        load_ready_b, core_hold_b, ram_we_b, chk_ready_b, done_b, busy_b;
    logic [31:0] ram_addr_b, ram_wdata_b, ram_rdata_b;
    logic [1:0]  pass_cnt_b, fail_cnt_b;
    state_t      dbg_state_b;
`ifdef RAM_CHK_FAILCAP_EN
    logic [31:0] fail_addr_a, fail_got_a, fail_addr_b, fail_got_b;
    logic        fail_seen_a, fail_seen_b;
`endif

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        sel_b = 1'b0;

    logic        cur_load_ready, cur_core_hold, cur_ram_we, cur_chk_ready, cur_done, cur_busy;
    logic [31:0] cur_ram_addr, cur_ram_wdata;
    logic [15:0] cur_pass, cur_fail;
    state_t      cur_state;

    assign cur_load_ready = sel_b ? load_ready_b : load_ready_a;
    assign cur_core_hold  = sel_b ? core_hold_b  : core_hold_a;
    assign cur_ram_we     = sel_b ? ram_we_b     : ram_we_a;
    assign cur_ram_addr   = sel_b ? ram_addr_b   : ram_addr_a;
    assign cur_ram_wdata  = sel_b ? ram_wdata_b  : ram_wdata_a;
    assign cur_chk_ready  = sel_b ? chk_ready_b  : chk_ready_a;
    assign cur_done       = sel_b ? done_b       : done_a;
    assign cur_busy       = sel_b ? busy_b       : busy_a;
    assign cur_pass       = sel_b ? {14'd0, pass_cnt_b} : pass_cnt_a;
    assign cur_fail       = sel_b ? {14'd0, fail_cnt_b} : fail_cnt_a;
    assign cur_state      = sel_b ? dbg_state_b  : dbg_state_a;

    // ---------------- clock / reset / RAM models ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a[7:0]] <= ram_wdata_a;
        ram_rdata_a <= mem_a[ram_addr_a[7:0]];
    end
    always @(posedge clk) begin
        if (ram_we_b) mem_b[ram_addr_b[7:0]] <= ram_wdata_b;
    end
    assign ram_rdata_b = mem_b[ram_addr_b[7:0]];

    ram_load_check_ctrl #(.AW(32), .DW(32), .RUN_CYCLES(30), .CW(16), .RD_LAT(1)) u_dut_a (
        .clk(clk), .reset(rst_n), .start(start_a),
        .load_valid(load_valid), .load_ready(load_ready_a), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last), .core_hold(core_hold_a),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a),
        .chk_valid(chk_valid), .chk_ready(chk_ready_a), .chk_addr(chk_addr),
        .chk_expect(chk_expect), .chk_neq(chk_neq), .chk_last(chk_last),
        .pass_cnt(pass_cnt_a), .fail_cnt(fail_cnt_a), .done(done_a), .busy(busy_a),
`ifdef RAM_CHK_FAILCAP_EN
        .fail_addr(fail_addr_a), .fail_got(fail_got_a), .fail_seen(fail_seen_a),
`endif
        .dbg_state(dbg_state_a)
    );

    ram_load_check_ctrl #(.AW(32), .DW(32), .RUN_CYCLES(3), .CW(2), .RD_LAT(0)) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start_b),
        .load_valid(load_valid), .load_ready(load_ready_b), .load_addr(load_addr),
        .load_data(load_data), .load_last(load_last), .core_hold(core_hold_b),
        .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
        .chk_valid(chk_valid), .chk_ready(chk_ready_b), .chk_addr(chk_addr),
        .chk_expect(chk_expect), .chk_neq(chk_neq), .chk_last(chk_last),
        .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b), .done(done_b), .busy(busy_b),
`ifdef RAM_CHK_FAILCAP_EN
        .fail_addr(fail_addr_b), .fail_got(fail_got_b), .fail_seen(fail_seen_b),
`endif
        .dbg_state(dbg_state_b)
    );

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic b);
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // One preload word; the RAM port must carry it during the accept cycle.
    task automatic drive_load(input logic [31:0] a, input logic [31:0] d, input logic last);
        int n;
        logic [63:0] e;
        load_valid = 1'b1; load_addr = a; load_data = d; load_last = last;
        exp_q.push_back({a, d});
        #1;
        n = 0;
        while (cur_load_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (cur_load_ready !== 1'b1) begin
            n_errors++; $display("FAIL load_ready_wait got=%b want=1", cur_load_ready);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({cur_ram_we, cur_ram_addr, cur_ram_wdata} !== {1'b1, e}) begin
            n_errors++;
            $display("FAIL load_ram_port got we=%b a=%h d=%h want we=1 a=%h d=%h",
                     cur_ram_we, cur_ram_addr, cur_ram_wdata, e[63:32], e[31:0]);
        end
        n_checks++;
        if (cur_core_hold !== 1'b1) begin
            n_errors++; $display("FAIL load_core_hold got=%b want=1", cur_core_hold);
        end
        @(posedge clk); #1;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    // Core model for n RUN cycles. mode 0: stores 0x7@0x60, v64@0x64 and
    // 0x68@0x14 in the final cycle. mode 1: no stores.
    task automatic run_core(input int n, input int mode, input logic [31:0] v64);
        for (int c = 0; c < n; c++) begin
            core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
            if (mode == 0) begin
                if (c == 0)          begin core_we = 1'b1; core_addr = 32'h60; core_wdata = 32'h7;  end
                else if (c == 1)     begin core_we = 1'b1; core_addr = 32'h64; core_wdata = v64;    end
                else if (c == n - 1) begin core_we = 1'b1; core_addr = 32'h14; core_wdata = 32'h68; end
            end
            #1;
            n_checks++;
            if (cur_core_hold !== 1'b0) begin
                n_errors++; $display("FAIL run_core_hold cycle=%0d got=%b want=0", c, cur_core_hold);
            end
            n_checks++;
            if ({cur_ram_we, cur_ram_addr, cur_ram_wdata} !== {core_we, core_addr, core_wdata}) begin
                n_errors++;
                $display("FAIL run_ram_port cycle=%0d got we=%b a=%h d=%h want we=%b a=%h d=%h", c,
                         cur_ram_we, cur_ram_addr, cur_ram_wdata, core_we, core_addr, core_wdata);
            end
            @(posedge clk); #1;
        end
        // Idle core keeps asserting a junk store; the controller must block it.
        core_we = 1'b1; core_addr = 32'h60; core_wdata = 32'hBAD;
        #1;
        n_checks++;
        if ({cur_core_hold, cur_state, cur_ram_we} !== {1'b1, CHECK, 1'b0}) begin
            n_errors++;
            $display("FAIL run_end got hold=%b state=%0d we=%b want hold=1 state=%0d we=0",
                     cur_core_hold, cur_state, cur_ram_we, CHECK);
        end
    endtask

    task automatic issue_check(input logic [31:0] a, input logic [31:0] e, input logic neq,
                               input logic last, output int acc);
        int n;
        chk_valid = 1'b1; chk_addr = a; chk_expect = e; chk_neq = neq; chk_last = last;
        #1;
        n = 0;
        while (cur_chk_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (cur_chk_ready !== 1'b1) begin
            n_errors++; $display("FAIL chk_ready_wait addr=%h got=%b want=1", a, cur_chk_ready);
        end
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (cur_done !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if ({cur_done, cur_busy, cur_state} !== {1'b1, 1'b0, DONE}) begin
            n_errors++;
            $display("FAIL done_state got done=%b busy=%b state=%0d want done=1 busy=0 state=%0d",
                     cur_done, cur_busy, cur_state, DONE);
        end
    endtask

    task automatic check_spacing(input int acc[6], input int cnt, input int gap, input string tag);
        for (int i = 1; i < cnt; i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] !== gap) begin
                n_errors++;
                $display("FAIL %s_spacing idx=%0d got=%0d want=%0d", tag, i, acc[i] - acc[i-1], gap);
            end
        end
    endtask

    task automatic check_counts(input logic [15:0] p, input logic [15:0] f, input string tag);
        n_checks++;
        if ({cur_pass, cur_fail} !== {p, f}) begin
            n_errors++;
            $display("FAIL %s_counts got pass=%0d fail=%0d want pass=%0d fail=%0d",
                     tag, cur_pass, cur_fail, p, f);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel_b = s[0];
            #1;
            n_checks++;
            if ({cur_state, cur_core_hold, cur_done, cur_busy, cur_ram_we, cur_load_ready, cur_chk_ready}
                !== {IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL reset_ctrl dut=%0d got st=%0d hold=%b done=%b busy=%b we=%b lr=%b cr=%b want st=0 hold=1 rest=0",
                         s, cur_state, cur_core_hold, cur_done, cur_busy, cur_ram_we, cur_load_ready, cur_chk_ready);
            end
            n_checks++;
            if ({cur_ram_addr, cur_ram_wdata} !== 64'h0) begin
                n_errors++;
                $display("FAIL reset_ram dut=%0d got a=%h d=%h want 0", s, cur_ram_addr, cur_ram_wdata);
            end
            check_counts(16'd0, 16'd0, "reset");
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Abort during LOAD after two of four words.
        sel_b = 1'b0;
        pulse_start(1'b0);
        drive_load(32'h30, 32'hA1, 1'b0);
        drive_load(32'h34, 32'hA2, 1'b0);
        load_valid = 1'b1; load_addr = 32'h38; load_data = 32'hA3; load_last = 1'b0;
        #1;
        n_checks++;
        if (cur_ram_we !== 1'b1) begin
            n_errors++; $display("FAIL abort_pre_we got=%b want=1", cur_ram_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cur_ram_we, cur_state, cur_core_hold, cur_load_ready} !== {1'b0, IDLE, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL abort_ctrl got we=%b st=%0d hold=%b lr=%b want we=0 st=0 hold=1 lr=0",
                     cur_ram_we, cur_state, cur_core_hold, cur_load_ready);
        end
        check_counts(16'd0, 16'd0, "abort");
        load_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (mem_a[8'h38] === 32'hA3 || mem_a[8'h34] !== 32'hA2) begin
            n_errors++;
            $display("FAIL abort_ram got m38=%h m34=%h want m38!=a3 m34=a2", mem_a[8'h38], mem_a[8'h34]);
        end
    endtask

    // Full RD_LAT=1 sequence on DUT A; v64 is what the core stores at 0x64.
    task automatic test_sequence_a(input logic [31:0] v64, input logic [15:0] ep,
                                   input logic [15:0] ef, input string tag);
        int acc[6];
        sel_b = 1'b0;
        pulse_start(1'b0);
        n_checks++;
        if ({cur_state, cur_busy, cur_done} !== {LOAD, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL %s_start got st=%0d busy=%b done=%b want st=%0d busy=1 done=0",
                     tag, cur_state, cur_busy, cur_done, LOAD);
        end
        check_counts(16'd0, 16'd0, {tag, "_start"});
`ifdef RAM_CHK_FAILCAP_EN
        n_checks++;
        if (fail_seen_a !== 1'b0) begin
            n_errors++; $display("FAIL %s_failcap_clear got=%b want=0", tag, fail_seen_a);
        end
`endif
        drive_load(32'h02, 32'h07, 1'b0);
        drive_load(32'h0F, 32'h11, 1'b0);
        drive_load(32'h60, 32'h00, 1'b0);
        drive_load(32'h64, 32'h00, 1'b1);
        n_checks++;
        if ({cur_core_hold, cur_state} !== {1'b0, RUN}) begin
            n_errors++;
            $display("FAIL %s_release got hold=%b st=%0d want hold=0 st=%0d", tag, cur_core_hold, cur_state, RUN);
        end
        run_core(30, 0, v64);
        issue_check(32'h60, 32'h07, 1'b0, 1'b0, acc[0]);
        issue_check(32'h64, 32'h19, 1'b0, 1'b0, acc[1]);
        issue_check(32'h02, 32'h07, 1'b0, 1'b0, acc[2]);
        issue_check(32'h0F, 32'h44, 1'b1, 1'b0, acc[3]);
        issue_check(32'h14, 32'h68, 1'b0, 1'b1, acc[4]);
        chk_valid = 1'b0; chk_last = 1'b0;
        check_spacing(acc, 5, 2, tag);
        wait_done();
        check_counts(ep, ef, tag);
        @(posedge clk); #1;
        check_counts(ep, ef, {tag, "_hold"});
`ifdef RAM_CHK_FAILCAP_EN
        n_checks++;
        if (ef == 16'd0) begin
            if (fail_seen_a !== 1'b0) begin
                n_errors++; $display("FAIL %s_failcap got seen=%b want=0", tag, fail_seen_a);
            end
        end else if ({fail_seen_a, fail_addr_a, fail_got_a} !== {1'b1, 32'h64, v64}) begin
            n_errors++;
            $display("FAIL %s_failcap got seen=%b a=%h d=%h want seen=1 a=64 d=%h",
                     tag, fail_seen_a, fail_addr_a, fail_got_a, v64);
        end
`endif
    endtask

    // DUT B (CW=2, RD_LAT=0): six failing checks back to back saturate fail_cnt.
    task automatic test_saturate();
        int acc[6];
        sel_b = 1'b1;
        pulse_start(1'b1);
        drive_load(32'h10, 32'h05, 1'b1);
        n_checks++;
        if (cur_core_hold !== 1'b0) begin
            n_errors++; $display("FAIL sat_single_word_release got=%b want=0", cur_core_hold);
        end
        run_core(3, 1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            issue_check(32'h10, 32'h05, 1'b1, (i == 5), acc[i]);
        end
        chk_valid = 1'b0; chk_last = 1'b0;
        check_spacing(acc, 6, 1, "sat");
        wait_done();
        check_counts(16'd0, 16'd3, "sat");
`ifdef RAM_CHK_FAILCAP_EN
        n_checks++;
        if ({fail_seen_b, fail_addr_b, fail_got_b} !== {1'b1, 32'h10, 32'h05}) begin
            n_errors++;
            $display("FAIL sat_failcap got seen=%b a=%h d=%h want seen=1 a=10 d=5",
                     fail_seen_b, fail_addr_b, fail_got_b);
        end
`endif
    endtask

    // Restart DUT B from DONE: counters clear, mixed results one per cycle.
    task automatic test_back_to_back();
        int acc[6];
        sel_b = 1'b1;
        pulse_start(1'b1);
        check_counts(16'd0, 16'd0, "b2b_start");
        n_checks++;
        if ({cur_done, cur_busy, cur_state} !== {1'b0, 1'b1, LOAD}) begin
            n_errors++;
            $display("FAIL b2b_start_state got done=%b busy=%b st=%0d want done=0 busy=1 st=%0d",
                     cur_done, cur_busy, cur_state, LOAD);
        end
`ifdef RAM_CHK_FAILCAP_EN
        n_checks++;
        if (fail_seen_b !== 1'b0) begin
            n_errors++; $display("FAIL b2b_failcap_clear got=%b want=0", fail_seen_b);
        end
`endif
        drive_load(32'h10, 32'h05, 1'b1);
        run_core(3, 1, 32'h0);
        issue_check(32'h10, 32'h05, 1'b0, 1'b0, acc[0]);
        issue_check(32'h10, 32'h06, 1'b1, 1'b0, acc[1]);
        issue_check(32'h10, 32'h09, 1'b0, 1'b1, acc[2]);
        chk_valid = 1'b0; chk_last = 1'b0;
        check_spacing(acc, 3, 1, "b2b");
        wait_done();
        check_counts(16'd2, 16'd1, "b2b");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; load_addr = '0; load_data = '0;
        core_we = 1'b1; core_addr = 32'h60; core_wdata = 32'hBAD;
        chk_valid = 1'b0; chk_neq = 1'b0; chk_last = 1'b0; chk_addr = '0; chk_expect = '0;

        test_reset();
        test_sequence_a(32'h19, 16'd5, 16'd0, "seq_pass");
        test_sequence_a(32'h18, 16'd4, 16'd1, "seq_fail");
        test_saturate();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
